nf_10g_link_sequencer: RTL

Bring-up and supervision controller for one 10G port. It sequences the transceiver resets (gttxreset/gtrxreset, txuserrdy), SFP tx_disable and the MAC AXIS reset that feed the nonshared 10G MAC/PCS instance. It then watches PCS block lock and the SFP fault and absence pins. It retries bring-up on timeout or lock loss, and exposes link state and a retry counter for the status path.

---
 rtl/nf_10g_link_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/nf_10g_link_sequencer.sv
// Bring-up and supervision sequencer for one 10G port: GT resets, SFP laser
// control, MAC reset release, link monitoring and retry accounting.
module nf_10g_link_sequencer #(
  parameter int unsigned C_GT_RESET_CYCLES = 32,
  parameter int unsigned C_TIMEOUT_CYCLES  = 1048576,
  parameter int unsigned C_DEBOUNCE_CYCLES = 16,
  parameter int unsigned C_TIMER_WIDTH     = 24
) (
  input  logic        clk156,
  input  logic        areset_clk156,
  input  logic        enable,
  input  logic        qplllock,
  input  logic        reset_counter_done,
  input  logic        tx_resetdone,
  input  logic        rx_resetdone,
  input  logic        pcs_block_lock,
  input  logic        tx_abs,
  input  logic        tx_fault,
  output logic        gttxreset,
  output logic        gtrxreset,
  output logic        txuserrdy,
  output logic        tx_disable,
  output logic        mac_aresetn,
  output logic        link_up,
  output logic [15:0] retry_count,
  output logic [2:0]  seq_state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GT_RST    = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_LINK_UP   = 3'd4,
    ST_RETRY     = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  localparam logic [C_TIMER_WIDTH-1:0] GT_LAST = C_TIMER_WIDTH'(C_GT_RESET_CYCLES - 1);
  localparam logic [C_TIMER_WIDTH-1:0] TO_LAST = C_TIMER_WIDTH'(C_TIMEOUT_CYCLES - 1);
  localparam logic [C_TIMER_WIDTH-1:0] DB_LAST = C_TIMER_WIDTH'(C_DEBOUNCE_CYCLES - 1);

  state_t                   state, next_state;
  logic [C_TIMER_WIDTH-1:0] timer;
  logic [C_TIMER_WIDTH-1:0] dbc;
  logic                     abs_meta, abs_s;
  logic                     flt_meta, flt_s;
  logic                     timeout;
  logic                     gt_rst_d, userrdy_d, txdis_d, mac_d, link_d;

  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156) begin
      abs_meta <= 1'b0;
      abs_s    <= 1'b0;
      flt_meta <= 1'b0;
      flt_s    <= 1'b0;
    end else begin
      abs_meta <= tx_abs;
      abs_s    <= abs_meta;
      flt_meta <= tx_fault;
      flt_s    <= flt_meta;
    end
  end

  assign timeout = (timer == TO_LAST);

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:
        if (enable && qplllock && reset_counter_done && !abs_s && !flt_s)
          next_state = ST_GT_RST;
      ST_GT_RST:
        if (timer == GT_LAST) next_state = ST_WAIT_DONE;
      ST_WAIT_DONE:
        if (tx_resetdone && rx_resetdone) next_state = ST_WAIT_LOCK;
        else if (timeout)                 next_state = ST_RETRY;
      ST_WAIT_LOCK:
        if (pcs_block_lock) next_state = ST_LINK_UP;
        else if (timeout)   next_state = ST_RETRY;
      ST_LINK_UP:
        if (!pcs_block_lock && dbc == DB_LAST) next_state = ST_RETRY;
      ST_RETRY:
        next_state = ST_GT_RST;
      ST_FAULT:
        if (!flt_s && dbc == DB_LAST) next_state = ST_IDLE;
      default:
        next_state = ST_IDLE;
    endcase

    // Overrides are applied last so they win over any local transition.
    if (!enable)
      next_state = ST_IDLE;
    else if (!qplllock && state != ST_IDLE && state != ST_FAULT)
      next_state = ST_IDLE;
    else if (abs_s)
      next_state = ST_IDLE;
    else if (flt_s && state != ST_FAULT)
      next_state = ST_FAULT;
  end

  always_comb begin
    gt_rst_d  = 1'b1;
    userrdy_d = 1'b0;
    txdis_d   = 1'b1;
    mac_d     = 1'b0;
    link_d    = 1'b0;
    case (next_state)
      ST_WAIT_DONE: gt_rst_d = 1'b0;
      ST_WAIT_LOCK: begin
        gt_rst_d  = 1'b0;
        userrdy_d = 1'b1;
        txdis_d   = 1'b0;
      end
      ST_LINK_UP: begin
        gt_rst_d  = 1'b0;
        userrdy_d = 1'b1;
        txdis_d   = 1'b0;
        mac_d     = 1'b1;
        link_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156) begin
      state       <= ST_IDLE;
      gttxreset   <= 1'b1;
      gtrxreset   <= 1'b1;
      txuserrdy   <= 1'b0;
      tx_disable  <= 1'b1;
      mac_aresetn <= 1'b0;
      link_up     <= 1'b0;
    end else begin
      state       <= next_state;
      gttxreset   <= gt_rst_d;
      gtrxreset   <= gt_rst_d;
      txuserrdy   <= userrdy_d;
      tx_disable  <= txdis_d;
      mac_aresetn <= mac_d;
      link_up     <= link_d;
    end
  end

  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156)
      timer <= '0;
    else if (next_state != state)
      timer <= '0;
    else if (timer != '1)
      timer <= timer + 1'b1;
  end

  // Shared run-length counter: lock-low cycles in LINK_UP, fault-clear cycles in FAULT.
  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156)
      dbc <= '0;
    else if (next_state != state)
      dbc <= '0;
    else if ((state == ST_LINK_UP && !pcs_block_lock) || (state == ST_FAULT && !flt_s)) begin
      if (dbc != '1) dbc <= dbc + 1'b1;
    end else
      dbc <= '0;
  end

  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156)
      retry_count <= '0;
    else if (next_state == ST_RETRY && retry_count != '1)
      retry_count <= retry_count + 16'd1;
  end

  assign seq_state = state;

endmodule
